// File: rtl/instr_fetch.sv
// Instruction fetch unit: requests a word, latches it, then issues it either as one
// long instruction or as two 16-bit shorts (upper slot first), with stall and redirect.
module instr_fetch #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  jump_en,
  input  logic [ADDR_WIDTH-1:0] jump_addr,
  input  logic                  jump_half,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [WIDTH-1:0]      mem_rdata,
  output logic [WIDTH-1:0]      long_instr,
  output logic                  instr_choose,
  output logic                  instr_valid,
  output logic [ADDR_WIDTH-1:0] cur_pc
);

  typedef enum logic [1:0] {S_REQ, S_LATCH, S_HI, S_LO} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] pc, pc_nxt, cur_pc_nxt;
  logic [WIDTH-1:0]      long_nxt;
  logic                  half, half_nxt;

  assign mem_addr     = pc;
  assign instr_valid  = (state == S_HI) || (state == S_LO);
  assign instr_choose = (state == S_LO);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_REQ;
      pc         <= '0;
      cur_pc     <= '0;
      long_instr <= '0;
      half       <= 1'b0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      cur_pc     <= cur_pc_nxt;
      long_instr <= long_nxt;
      half       <= half_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    cur_pc_nxt = cur_pc;
    long_nxt   = long_instr;
    half_nxt   = half;
    // A redirect wins in every state; a word arriving in S_LATCH is dropped.
    if (jump_en) begin
      pc_nxt    = jump_addr;
      half_nxt  = jump_half;
      state_nxt = S_REQ;
    end else begin
      unique case (state)
        S_REQ:   state_nxt = S_LATCH;
        S_LATCH: begin
          long_nxt   = mem_rdata;
          cur_pc_nxt = pc;
          pc_nxt     = pc + ADDR_WIDTH'(1);
          half_nxt   = 1'b0;
          // A half-slot target only applies when the word really holds two shorts.
          state_nxt  = (half && !mem_rdata[WIDTH-1]) ? S_LO : S_HI;
        end
        S_HI: begin
          if (en) state_nxt = long_instr[WIDTH-1] ? S_REQ : S_LO;
        end
        S_LO: begin
          if (en) state_nxt = S_REQ;
        end
        default: state_nxt = S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch: default-width instance plus a
// 4-bit address instance for pc wrap.
module tb_instr_fetch;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // default instance
  logic        rst_n, en, jump_en, jump_half;
  logic [15:0] jump_addr, mem_addr, cur_pc;
  logic [31:0] mem_rdata, long_instr;
  logic        instr_choose, instr_valid;
  logic [31:0] mem [0:65535];

  // ADDR_WIDTH=4 instance
  logic        rst4_n, en4, jump_en4, jump_half4;
  logic [3:0]  jump_addr4, mem_addr4, cur_pc4;
  logic [31:0] mem_rdata4, long4;
  logic        choose4, valid4;
  logic [31:0] mem4 [0:15];

  instr_fetch dut (
    .clk(clk), .rst_n(rst_n), .en(en), .jump_en(jump_en), .jump_addr(jump_addr),
    .jump_half(jump_half), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .long_instr(long_instr), .instr_choose(instr_choose), .instr_valid(instr_valid),
    .cur_pc(cur_pc)
  );

  instr_fetch #(.WIDTH(32), .ADDR_WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst4_n), .en(en4), .jump_en(jump_en4), .jump_addr(jump_addr4),
    .jump_half(jump_half4), .mem_addr(mem_addr4), .mem_rdata(mem_rdata4),
    .long_instr(long4), .instr_choose(choose4), .instr_valid(valid4),
    .cur_pc(cur_pc4)
  );

  // synchronous memories: data valid one cycle after the address is sampled
  always @(posedge clk) begin
    mem_rdata  <= mem[mem_addr];
    mem_rdata4 <= mem4[mem_addr4];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b1; jump_en = 1'b0; jump_half = 1'b0; jump_addr = '0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_long();
    mem[0] = 32'h8C00_1234;
    mem[1] = 32'h9000_0001;
    do_reset();
    n_checks++; if (mem_addr !== 16'h0000) begin n_fail++; $display("FAIL long_c0_addr: got %h expected 0000", mem_addr); end
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL long_c0_valid: got %b expected 0", instr_valid); end
    tick();
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL long_c1_valid: got %b expected 0", instr_valid); end
    tick();
    n_checks++; if ({instr_valid, instr_choose} !== 2'b10) begin n_fail++; $display("FAIL long_c2_vc: got %b expected 10", {instr_valid, instr_choose}); end
    n_checks++; if (long_instr !== 32'h8C00_1234) begin n_fail++; $display("FAIL long_c2_instr: got %h expected 8c001234", long_instr); end
    n_checks++; if (cur_pc !== 16'h0000) begin n_fail++; $display("FAIL long_c2_pc: got %h expected 0000", cur_pc); end
    tick();
    n_checks++; if (mem_addr !== 16'h0001) begin n_fail++; $display("FAIL long_c3_addr: got %h expected 0001", mem_addr); end
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL long_c3_valid: got %b expected 0", instr_valid); end
  endtask

  task automatic test_reset();
    // busy state from the previous test; reset must override jump_en and en
    rst_n = 1'b0; en = 1'b1; jump_en = 1'b1; jump_addr = 16'h0077; jump_half = 1'b1;
    tick();
    n_checks++; if ({instr_valid, instr_choose} !== 2'b00) begin n_fail++; $display("FAIL rst_vc: got %b expected 00", {instr_valid, instr_choose}); end
    n_checks++; if (mem_addr !== 16'h0000) begin n_fail++; $display("FAIL rst_addr: got %h expected 0000", mem_addr); end
    n_checks++; if (cur_pc !== 16'h0000) begin n_fail++; $display("FAIL rst_pc: got %h expected 0000", cur_pc); end
    n_checks++; if (long_instr !== 32'h0) begin n_fail++; $display("FAIL rst_instr: got %h expected 00000000", long_instr); end
    jump_en = 1'b0; jump_half = 1'b0;
  endtask

  task automatic test_shorts();
    mem[0] = 32'h4801_2402;
    mem[1] = 32'h9000_0001;
    do_reset();
    tick(); tick();
    n_checks++; if ({instr_valid, instr_choose} !== 2'b10) begin n_fail++; $display("FAIL sh_c2_vc: got %b expected 10", {instr_valid, instr_choose}); end
    n_checks++; if (long_instr !== 32'h4801_2402) begin n_fail++; $display("FAIL sh_c2_instr: got %h expected 48012402", long_instr); end
    tick();
    n_checks++; if ({instr_valid, instr_choose} !== 2'b11) begin n_fail++; $display("FAIL sh_c3_vc: got %b expected 11", {instr_valid, instr_choose}); end
    tick();
    n_checks++; if ({instr_valid, mem_addr} !== {1'b0, 16'h0001}) begin n_fail++; $display("FAIL sh_c4: got v=%b a=%h expected v=0 a=0001", instr_valid, mem_addr); end
    tick();
    n_checks++; if ({instr_valid, mem_addr} !== {1'b0, 16'h0001}) begin n_fail++; $display("FAIL sh_c5: got v=%b a=%h expected v=0 a=0001", instr_valid, mem_addr); end
    tick();
    n_checks++; if ({instr_valid, instr_choose, cur_pc} !== {2'b10, 16'h0001}) begin n_fail++; $display("FAIL sh_c6: got v=%b c=%b pc=%h expected v=1 c=0 pc=0001", instr_valid, instr_choose, cur_pc); end
    n_checks++; if (long_instr !== 32'h9000_0001) begin n_fail++; $display("FAIL sh_c6_instr: got %h expected 90000001", long_instr); end
  endtask

  task automatic test_stall();
    mem[0] = 32'h4801_2402;
    do_reset();
    tick(); tick(); tick();   // now in the lower slot
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if ({instr_valid, instr_choose} !== 2'b11) begin n_fail++; $display("FAIL stall_vc%0d: got %b expected 11", i, {instr_valid, instr_choose}); end
      n_checks++; if ({long_instr, cur_pc} !== {32'h4801_2402, 16'h0000}) begin n_fail++; $display("FAIL stall_hold%0d: got %h/%h expected 48012402/0000", i, long_instr, cur_pc); end
    end
    en = 1'b1;
    tick();
    n_checks++; if ({instr_valid, mem_addr} !== {1'b0, 16'h0001}) begin n_fail++; $display("FAIL stall_release: got v=%b a=%h expected v=0 a=0001", instr_valid, mem_addr); end
  endtask

  task automatic test_jump_half();
    mem[0]    = 32'h8C00_1234;
    mem[16'h40] = 32'h1234_5678;
    do_reset();
    tick(); tick();           // S_HI on a long word
    jump_en = 1'b1; jump_addr = 16'h0040; jump_half = 1'b1;
    tick();
    jump_en = 1'b0; jump_half = 1'b0;
    n_checks++; if ({instr_valid, mem_addr} !== {1'b0, 16'h0040}) begin n_fail++; $display("FAIL jh_redir: got v=%b a=%h expected v=0 a=0040", instr_valid, mem_addr); end
    tick();
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL jh_latch_valid: got %b expected 0", instr_valid); end
    tick();
    n_checks++; if ({instr_valid, instr_choose, cur_pc} !== {2'b11, 16'h0040}) begin n_fail++; $display("FAIL jh_issue: got v=%b c=%b pc=%h expected v=1 c=1 pc=0040", instr_valid, instr_choose, cur_pc); end
    n_checks++; if (long_instr !== 32'h1234_5678) begin n_fail++; $display("FAIL jh_instr: got %h expected 12345678", long_instr); end
    tick();
    n_checks++; if ({instr_valid, mem_addr} !== {1'b0, 16'h0041}) begin n_fail++; $display("FAIL jh_next: got v=%b a=%h expected v=0 a=0041", instr_valid, mem_addr); end
  endtask

  task automatic test_jump_long();
    mem[0]      = 32'h8C00_1234;
    mem[16'h40] = 32'hC000_00AA;
    do_reset();
    tick(); tick();
    en = 1'b0; jump_en = 1'b1; jump_addr = 16'h0040; jump_half = 1'b1;
    tick();
    jump_en = 1'b0; jump_half = 1'b0;
    n_checks++; if ({instr_valid, mem_addr} !== {1'b0, 16'h0040}) begin n_fail++; $display("FAIL jl_redir: got v=%b a=%h expected v=0 a=0040", instr_valid, mem_addr); end
    tick(); tick();
    n_checks++; if ({instr_valid, instr_choose, cur_pc} !== {2'b10, 16'h0040}) begin n_fail++; $display("FAIL jl_issue: got v=%b c=%b pc=%h expected v=1 c=0 pc=0040", instr_valid, instr_choose, cur_pc); end
    tick();   // en=0 holds the long word
    n_checks++; if ({instr_valid, instr_choose, long_instr} !== {2'b10, 32'hC000_00AA}) begin n_fail++; $display("FAIL jl_hold: got v=%b c=%b i=%h expected v=1 c=0 i=c00000aa", instr_valid, instr_choose, long_instr); end
    en = 1'b1;
  endtask

  task automatic test_jump_latch();
    mem[0]      = 32'h8C00_1234;
    mem[16'h20] = 32'h0000_0001;
    do_reset();
    tick();                   // S_LATCH: the incoming word must be dropped
    jump_en = 1'b1; jump_addr = 16'h0020; jump_half = 1'b0;
    tick();
    jump_en = 1'b0;
    n_checks++; if ({instr_valid, mem_addr, long_instr} !== {1'b0, 16'h0020, 32'h0}) begin n_fail++; $display("FAIL jlat_drop: got v=%b a=%h i=%h expected v=0 a=0020 i=00000000", instr_valid, mem_addr, long_instr); end
    tick(); tick();
    n_checks++; if ({instr_valid, instr_choose, long_instr} !== {2'b10, 32'h0000_0001}) begin n_fail++; $display("FAIL jlat_issue: got v=%b c=%b i=%h expected v=1 c=0 i=00000001", instr_valid, instr_choose, long_instr); end
  endtask

  task automatic test_wrap();
    mem4[4'hF] = 32'h8000_000F;
    mem4[4'h0] = 32'h0001_0002;
    rst4_n = 1'b0; en4 = 1'b1; jump_en4 = 1'b0; jump_half4 = 1'b0; jump_addr4 = '0;
    tick(); tick();
    rst4_n = 1'b1;
    jump_en4 = 1'b1; jump_addr4 = 4'hF;
    tick();
    jump_en4 = 1'b0;
    n_checks++; if (mem_addr4 !== 4'hF) begin n_fail++; $display("FAIL wrap_redir: got %h expected f", mem_addr4); end
    tick(); tick();
    n_checks++; if ({valid4, choose4, cur_pc4} !== {2'b10, 4'hF}) begin n_fail++; $display("FAIL wrap_issue: got v=%b c=%b pc=%h expected v=1 c=0 pc=f", valid4, choose4, cur_pc4); end
    n_checks++; if (mem_addr4 !== 4'h0) begin n_fail++; $display("FAIL wrap_addr: got %h expected 0", mem_addr4); end
    tick(); tick(); tick(); tick();   // S_REQ, S_LATCH, S_HI, S_LO of the short pair at 0
    n_checks++; if ({valid4, choose4, cur_pc4} !== {2'b11, 4'h0}) begin n_fail++; $display("FAIL wrap_lo: got v=%b c=%b pc=%h expected v=1 c=1 pc=0", valid4, choose4, cur_pc4); end
    rst4_n = 1'b0;
    tick();
    n_checks++; if ({valid4, choose4, mem_addr4, long4} !== {2'b00, 4'h0, 32'h0}) begin n_fail++; $display("FAIL wrap_rst: got v=%b c=%b a=%h i=%h expected v=0 c=0 a=0 i=00000000", valid4, choose4, mem_addr4, long4); end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
    for (int i = 0; i < 16; i++) mem4[i] = 32'h0;
    rst4_n = 1'b0; en4 = 1'b1; jump_en4 = 1'b0; jump_half4 = 1'b0; jump_addr4 = '0;
    test_long();
    test_reset();
    test_shorts();
    test_stall();
    test_jump_half();
    test_jump_long();
    test_jump_latch();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
